cmem_loader: RTL and testbench
==============================

# cmem_loader

Coefficient loader that sits directly upstream of the FIR coefficient memory (`cmem`). It accepts a stream of 16-bit coefficients over a valid/ready handshake and writes them block-major into the eight 256-word cmem blocks. It drives cmem's active-low chip enable and write enable, the block select, the write address and the write data. It reports completion and a running XOR checksum so the host can confirm the load before filtering starts.

## Interface
- `NBLK`, default 8, number of cmem blocks (block select width is log2(NBLK)).
- `AW`, default 8, address width within a block (256 words).
- `DW`, default 16, coefficient width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  AW  taps per block, sampled at `start`; 0 means 256.
- `in_valid`  in  1  coefficient word present.
- `in_data`  in  DW  coefficient word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `cmem_CEN`  out  1  chip enable to cmem, active low.
- `cmem_WEN`  out  1  write enable to cmem, active low.
- `cmem_blk`  out  3  target block for the write.
- `cmem_A`  out  AW  write address within the block.
- `cmem_D`  out  DW  write data.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last write is issued.
- `csum`  out  DW  XOR of all words accepted in the current or last load.

## Operation
- FSM states:
  - IDLE: `in_ready`=0. On `start`: latch `load_len`, clear the block and index counters, clear `csum`, go to LOAD.
  - LOAD: `in_ready`=1. Each handshake (`in_valid` & `in_ready`):
    - registers a write with `cmem_blk`=blk, `cmem_A`=idx, `cmem_D`=`in_data`;
    - `csum` ^= `in_data`;
    - idx increments; when idx = len-1, idx wraps to 0 and blk increments.
    - The handshake that carries blk=NBLK-1, idx=len-1 moves the FSM to FLUSH.
  - FLUSH: the last registered write is presented for one cycle; `in_ready`=0. Go to DONE.
  - DONE: `done`=1 for exactly one cycle, `busy` drops. Go to IDLE.
- A load writes NBLK*len words in total. Addresses idx ≥ len in every block are left untouched.
- Write cycles drive `cmem_CEN`=0 and `cmem_WEN`=0. Every other cycle drives `cmem_CEN`=1 and `cmem_WEN`=1; `cmem_A`, `cmem_blk` and `cmem_D` then hold their last values.
- `start` is ignored outside IDLE.
- An `in_valid` gap in LOAD produces an idle cmem cycle. No counter advances during a gap.
- `csum` holds its value after DONE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=0, `busy`=0, `done`=0;
  - `cmem_CEN`=1, `cmem_WEN`=1;
  - `cmem_blk`=0, `cmem_A`=0, `cmem_D`=0, `csum`=0.
- All cmem outputs are registered. A handshake at edge N drives the write during cycle N→N+1, and cmem captures it at edge N+1. Write latency is one cycle.
- Throughput is one word per cycle with no stall cycles.
- Load of `start` at edge S:
  - `busy`=1 and `in_ready`=1 from S+1.
  - With continuous valid, the last handshake lands at S+NBLK*len.
  - `done` pulses in cycle S+NBLK*len+2.
- Block wrap: the handshake at idx=len-1 and the next one write consecutive cycles (blk b at len-1, then blk b+1 at 0) with no bubble.
- `rst` asserted mid-load: next cycle is IDLE with enables deasserted. Partially written cmem contents are undefined, and no `done` pulse is produced.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package `fir_pkg`:
  - `NBLK`, `AW`, `DW` constants;
  - active-low `ON`/`OFF` encodings (1'b0/1'b1) for CEN/WEN;
  - FSM state enum (IDLE, LOAD, FLUSH, DONE).
- Single module with no sub-modules. The blk/idx counter pair is simple enough to stay inline.

## Test plan
- Full load, `load_len`=0 (256), 2048 continuous words `in_data`=i → 2048 writes; blk 3 idx 17 receives 3*256+17=785; `done` at `start`+2050; `csum` = XOR of 0..2047 = 0.
- `load_len`=4, words 0x1000..0x101F → blk0 idx0..3 = 0x1000..0x1003, blk7 idx3 = 0x101F; exactly 32 write cycles; `done` once.
- `in_valid` toggled 1/0 every cycle, `load_len`=2 → CEN low only on cycles after handshakes; 16 writes over 32 cycles; addresses sequence correctly across gaps.
- `start` pulsed again mid-load, and `in_valid` held high in IDLE and DONE → no restart, `in_ready`=0 outside LOAD, no extra writes.
- `rst` asserted after 100 words of a 256-tap load → next cycle CEN=WEN=1, `busy`=0, no `done`; a fresh `start` then rewrites from blk0 idx0 with `csum` cleared.
- Reset with no stimulus → every output at its listed reset value; CEN/WEN remain 1 for 20 cycles.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient path.
//   NBLK, AW, DW : default cmem geometry (8 blocks of 256 x 16-bit words)
//   ON / OFF     : active-low chip/write enable encodings for cmem
//   state_t      : coefficient loader FSM states
package fir_pkg;

    localparam int NBLK = 8;
    localparam int AW   = 8;
    localparam int DW   = 16;

    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/cmem_loader_if.sv
// Coefficient stream and cmem write bus around cmem_loader.
//   in_valid/in_data/in_ready : valid/ready coefficient stream into the loader
//   cmem_CEN/cmem_WEN         : active-low chip and write enables to cmem
//   cmem_blk/cmem_A/cmem_D    : block select, word address and write data
// Modports: master = host side (drives the stream, observes cmem),
//           slave  = loader side.
interface cmem_loader_if #(
    parameter int NBLK = fir_pkg::NBLK,
    parameter int AW   = fir_pkg::AW,
    parameter int DW   = fir_pkg::DW
);

    localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1;

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    logic          cmem_CEN;
    logic          cmem_WEN;
    logic [BW-1:0] cmem_blk;
    logic [AW-1:0] cmem_A;
    logic [DW-1:0] cmem_D;

    modport master (
        output in_valid, in_data,
        input  in_ready,
        input  cmem_CEN, cmem_WEN, cmem_blk, cmem_A, cmem_D
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready,
        output cmem_CEN, cmem_WEN, cmem_blk, cmem_A, cmem_D
    );

endinterface

// File: rtl/cmem_loader.sv
// Coefficient loader for the FIR coefficient memory.
// Accepts a valid/ready stream of coefficients and writes them block-major
// into NBLK cmem blocks, len words per block, then pulses done. A running
// XOR of every accepted word is kept on csum for host-side confirmation.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a load (honoured only while idle)
//   load_len : taps per block, sampled with start; 0 means 2**AW
//   bus      : stream input and registered cmem write port (slave side)
//   busy     : load in progress (cycle after start up to done)
//   done     : one-cycle completion pulse
//   csum     : XOR of the words of the current or most recent load
module cmem_loader #(
    parameter int NBLK = fir_pkg::NBLK,
    parameter int AW   = fir_pkg::AW,
    parameter int DW   = fir_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   load_len,
    cmem_loader_if.slave    bus,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   csum
);

    import fir_pkg::*;

    localparam int            BW       = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [BW-1:0] LAST_BLK = BW'(NBLK - 1);

    state_t        state;
    logic [AW-1:0] len_m1;   // last index within a block; 0-1 wraps to 2**AW-1
    logic [AW-1:0] idx;
    logic [BW-1:0] blk;
    logic          hs;
    logic          last_word;

    assign hs        = bus.in_valid & bus.in_ready;
    assign last_word = (blk == LAST_BLK) && (idx == len_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.cmem_CEN <= OFF;
            bus.cmem_WEN <= OFF;
            bus.cmem_blk <= '0;
            bus.cmem_A   <= '0;
            bus.cmem_D   <= '0;
            csum         <= '0;
            len_m1       <= '0;
            idx          <= '0;
            blk          <= '0;
        end else begin
            // NOTE: enables and done default to inactive every cycle and are
            // only overridden below, so each write or pulse lasts one cycle.
            bus.cmem_CEN <= OFF;
            bus.cmem_WEN <= OFF;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        len_m1       <= load_len - 1'b1;
                        idx          <= '0;
                        blk          <= '0;
                        csum         <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= LOAD;
                    end
                end

                LOAD: begin
                    if (hs) begin
                        bus.cmem_CEN <= ON;
                        bus.cmem_WEN <= ON;
                        bus.cmem_blk <= blk;
                        bus.cmem_A   <= idx;
                        bus.cmem_D   <= bus.in_data;
                        csum         <= csum ^ bus.in_data;

                        if (idx == len_m1) begin
                            idx <= '0;
                            blk <= blk + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end

                        // Drop ready with the final word so nothing past
                        // the last block is ever accepted.
                        if (last_word) begin
                            bus.in_ready <= 1'b0;
                            state        <= FLUSH;
                        end
                    end
                end

                // The final write is on the cmem pins during this cycle.
                FLUSH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmem_loader.sv
// Self-checking bench for cmem_loader: randomized loads against a reference
// that derives every expected write from the word's position in the stream.
module tb_cmem_loader;

    localparam int NBLK = 8;
    localparam int AW   = 8;
    localparam int DW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] load_len;
    logic          busy;
    logic          done;
    logic [DW-1:0] csum;

    int checks = 0;
    int errors = 0;

    cmem_loader_if #(.NBLK(NBLK), .AW(AW), .DW(DW)) bus ();

    cmem_loader #(.NBLK(NBLK), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_len (load_len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .csum     (csum)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load. dmode: 0 data=i, 1 data=0x1000+i, 2 random.
    // vmode: 0 continuous valid, 1 alternate 1/0, 2 random (75% valid).
    // abort_at: word count at which rst is asserted (-1 none).
    // restart_at: cycle at which a stray start is pulsed (-1 none).
    task automatic run_load(input int len_in, input int dmode, input int vmode,
                            input int abort_at, input int restart_at);
        int          len;
        int          n;
        int          acc;
        int          cyc;
        logic        v;
        logic [DW-1:0] words[$];
        logic [DW-1:0] exp_csum;
        logic [DW-1:0] run_csum;

        len      = (len_in == 0) ? 256 : len_in;
        n        = NBLK * len;
        exp_csum = '0;
        run_csum = '0;
        for (int i = 0; i < n; i++) begin
            case (dmode)
                0:       words.push_back(DW'(i));
                1:       words.push_back(DW'(16'h1000 + i));
                default: words.push_back(DW'($urandom));
            endcase
            exp_csum ^= words[i];
        end

        start    = 1'b1;
        load_len = AW'(len_in);
        tick();
        start = 1'b0;
        check("start_busy",  busy,         1);
        check("start_ready", bus.in_ready, 1);
        check("start_csum",  csum,         0);

        acc = 0;
        cyc = 0;
        while (acc < n && cyc < 4 * n + 64) begin
            if (acc == abort_at) begin
                // rst together with start: reset must win.
                rst          = 1'b1;
                start        = 1'b1;
                bus.in_valid = 1'b1;
                tick();
                check("abort_en",    {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
                check("abort_busy",  busy,         0);
                check("abort_ready", bus.in_ready, 0);
                check("abort_done",  done,         0);
                check("abort_csum",  csum,         0);
                rst          = 1'b0;
                start        = 1'b0;
                bus.in_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("abort_nodone", done, 0);
                    check("abort_idle_en", {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
                end
                return;
            end

            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = v;
            bus.in_data  = v ? words[acc] : DW'($urandom);
            if (cyc == restart_at) begin
                start    = 1'b1;
                load_len = AW'($urandom);
            end
            tick();
            start = 1'b0;

            if (v) begin
                check("wr_en",   {bus.cmem_CEN, bus.cmem_WEN}, 2'b00);
                check("wr_blk",  bus.cmem_blk, acc / len);
                check("wr_addr", bus.cmem_A,   acc % len);
                check("wr_data", bus.cmem_D,   words[acc]);
                run_csum ^= words[acc];
                acc++;
            end else begin
                check("gap_en", {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
            end
            check("run_csum", csum, run_csum);
            if (acc < n) begin
                check("load_ready", bus.in_ready, 1);
                check("load_busy",  busy,         1);
                check("load_done",  done,         0);
            end
            cyc++;
        end
        check("load_count", acc, n);

        // Keep valid high past the last word: nothing more may be taken.
        bus.in_valid = 1'b1;
        bus.in_data  = DW'($urandom);
        check("flush_ready", bus.in_ready, 0);
        check("flush_busy",  busy,         1);
        check("flush_done",  done,         0);
        tick();
        check("done_pulse", done, 1);
        check("done_busy",  busy, 0);
        check("done_en",    {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        check("done_csum",  csum, exp_csum);
        check("done_ready", bus.in_ready, 0);
        tick();
        check("post_done",  done, 0);
        check("post_ready", bus.in_ready, 0);
        check("post_en",    {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        check("post_csum",  csum, exp_csum);
        tick();
        check("idle_ready", bus.in_ready, 0);
        check("idle_en",    {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        check("idle_busy",  busy, 0);
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        load_len     = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_ready", bus.in_ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_en",    {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        check("rst_blk",   bus.cmem_blk, 0);
        check("rst_addr",  bus.cmem_A, 0);
        check("rst_data",  bus.cmem_D, 0);
        check("rst_csum",  csum, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_hold_en", {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        end

        // Valid presented while idle must not be accepted or written.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid_ready", bus.in_ready, 0);
            check("idle_valid_en", {bus.cmem_CEN, bus.cmem_WEN}, 2'b11);
        end
        bus.in_valid = 1'b0;
        tick();

        run_load(0, 0, 0, -1, -1);    // full 8 x 256 load, data = i
        run_load(4, 1, 0, -1, -1);    // 0x1000.. in 4-tap blocks
        run_load(2, 2, 1, -1, -1);    // alternating valid
        run_load(3, 2, 2, -1, 7);     // stray start mid-load
        run_load(1, 2, 0, -1, -1);    // one tap per block
        run_load(0, 2, 0, 100, -1);   // reset after 100 words
        run_load(5, 2, 2, -1, -1);    // fresh load after reset
        for (int t = 0; t < 6; t++) begin
            run_load(int'($urandom_range(1, 12)), 2, 2, -1, int'($urandom_range(0, 20)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
